s_mem_phase_controller: RTL and testbench

Sequences the RC4 S-memory engines through three phases in order: init (S[i]=i), KSA shuffle, then PRGA decrypt. Owns the single-port 256x8 S RAM and muxes its address, data and write-enable from whichever engine currently holds the grant. Drives start strobes, watches done strobes, and enforces a per-phase timeout. Sits between the top-level switch/key logic and the three engine blocks.

---
 rtl/s_mem_phase_controller_if.sv | 34 +++
 rtl/s_mem_phase_controller.sv | 210 +++++++++++++++++++++
 tb/tb_s_mem_phase_controller.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/s_mem_phase_controller_if.sv
// Engine handshake and S RAM bus bundle for the RC4 phase controller.
// master = controller side, slave = engines / RAM side.
interface s_mem_phase_controller_if #(
   parameter int unsigned RAM_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  init_start, ksa_start, prga_start;
   logic                  init_done, ksa_done, prga_done;
   logic                  prga_key_ok;
   logic [ADDR_WIDTH-1:0] init_addr, ksa_addr, prga_addr;
   logic [RAM_WIDTH-1:0]  init_wdata, ksa_wdata, prga_wdata;
   logic                  init_we, ksa_we, prga_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [RAM_WIDTH-1:0]  ram_wdata;
   logic                  ram_we;

   modport master (
      output init_start, ksa_start, prga_start,
      input  init_done, ksa_done, prga_done, prga_key_ok,
      input  init_addr, ksa_addr, prga_addr,
      input  init_wdata, ksa_wdata, prga_wdata,
      input  init_we, ksa_we, prga_we,
      output ram_addr, ram_wdata, ram_we
   );

   modport slave (
      input  init_start, ksa_start, prga_start,
      output init_done, ksa_done, prga_done, prga_key_ok,
      output init_addr, ksa_addr, prga_addr,
      output init_wdata, ksa_wdata, prga_wdata,
      output init_we, ksa_we, prga_we,
      input  ram_addr, ram_wdata, ram_we
   );
endinterface

// File: rtl/s_mem_phase_controller.sv
// RC4 S-memory phase sequencer: init -> KSA -> PRGA with RAM arbitration and per-phase timeout.
// Optional KEY_SEARCH_EN: on a failed decrypt, retry with key_out+1 until KEY_MAX.
module s_mem_phase_controller #(
   parameter int unsigned          RAM_WIDTH      = 8,
   parameter int unsigned          ADDR_WIDTH     = 8,
   parameter int unsigned          KEY_WIDTH      = 24,
   parameter int unsigned          TIMEOUT_CYCLES = 4096,
   parameter logic [KEY_WIDTH-1:0] KEY_MAX        = 24'h3FFFFF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [KEY_WIDTH-1:0]   key_in,
   s_mem_phase_controller_if.master eng,
   output logic [1:0]             grant,
   output logic [KEY_WIDTH-1:0]   key_out,
   output logic                   busy,
   output logic                   done,
   output logic                   key_found,
   output logic                   error
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      StIdle, StInitGo, StInitWait, StKsaGo, StKsaWait, StPrgaGo, StPrgaWait, StDone, StError
   } state_e;

   state_e                 state_q, state_d;
   logic                   start_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [KEY_WIDTH-1:0]   key_out_q, key_out_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic                   key_found_q, key_found_d;
   logic [1:0]             grant_q, grant_d;
   logic                   init_start_q, init_start_d;
   logic                   ksa_start_q, ksa_start_d;
   logic                   prga_start_q, prga_start_d;
   logic                   start_edge;
   logic                   cnt_expired;
   logic [ADDR_WIDTH-1:0]  addr_mux;
   logic [RAM_WIDTH-1:0]   wdata_mux;
   logic                   we_mux;

   assign start_edge  = start & ~start_q;
   assign cnt_expired = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_out_d   = key_out_q;
      done_d      = done_q;
      error_d     = error_q;
      key_found_d = key_found_q;

      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start_edge) begin
               state_d     = StInitGo;
               key_out_d   = key_in;
               done_d      = 1'b0;
               error_d     = 1'b0;
               key_found_d = 1'b0;
            end
         end
         StInitGo: begin
            state_d = StInitWait;
            cnt_d   = '0;
         end
         StInitWait: begin
            if (eng.init_done) begin
               state_d = StKsaGo;
            end else if (cnt_expired) begin
               state_d = StError;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StKsaGo: begin
            state_d = StKsaWait;
            cnt_d   = '0;
         end
         StKsaWait: begin
            if (eng.ksa_done) begin
               state_d = StPrgaGo;
            end else if (cnt_expired) begin
               state_d = StError;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPrgaGo: begin
            state_d = StPrgaWait;
            cnt_d   = '0;
         end
         StPrgaWait: begin
            if (eng.prga_done) begin
`ifdef KEY_SEARCH_EN
               if (!eng.prga_key_ok && (key_out_q < KEY_MAX)) begin
                  // Failed decrypt: rerun all three phases with the next key.
                  state_d   = StInitGo;
                  key_out_d = key_out_q + KEY_WIDTH'(1);
               end else begin
                  state_d     = StDone;
                  done_d      = 1'b1;
                  key_found_d = eng.prga_key_ok;
               end
`else
               state_d     = StDone;
               done_d      = 1'b1;
               key_found_d = eng.prga_key_ok;
`endif
            end else if (cnt_expired) begin
               state_d = StError;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Grant and start strobes are registered from the state being entered.
      grant_d = 2'd0;
      unique case (state_d)
         StInitGo, StInitWait: grant_d = 2'd1;
         StKsaGo, StKsaWait:   grant_d = 2'd2;
         StPrgaGo, StPrgaWait: grant_d = 2'd3;
         default:              grant_d = 2'd0;
      endcase
      init_start_d = (state_d == StInitGo);
      ksa_start_d  = (state_d == StKsaGo);
      prga_start_d = (state_d == StPrgaGo);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         start_q      <= 1'b0;
         cnt_q        <= '0;
         key_out_q    <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         key_found_q  <= 1'b0;
         grant_q      <= 2'd0;
         init_start_q <= 1'b0;
         ksa_start_q  <= 1'b0;
         prga_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start;
         cnt_q        <= cnt_d;
         key_out_q    <= key_out_d;
         done_q       <= done_d;
         error_q      <= error_d;
         key_found_q  <= key_found_d;
         grant_q      <= grant_d;
         init_start_q <= init_start_d;
         ksa_start_q  <= ksa_start_d;
         prga_start_q <= prga_start_d;
      end
   end

   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      we_mux    = 1'b0;
      unique case (grant_q)
         2'd1: begin
            addr_mux  = eng.init_addr;
            wdata_mux = eng.init_wdata;
            we_mux    = eng.init_we;
         end
         2'd2: begin
            addr_mux  = eng.ksa_addr;
            wdata_mux = eng.ksa_wdata;
            we_mux    = eng.ksa_we;
         end
         2'd3: begin
            addr_mux  = eng.prga_addr;
            wdata_mux = eng.prga_wdata;
            we_mux    = eng.prga_we;
         end
         default: begin
            addr_mux  = '0;
            wdata_mux = '0;
            we_mux    = 1'b0;
         end
      endcase
   end

   assign eng.ram_addr   = addr_mux;
   assign eng.ram_wdata  = wdata_mux;
   assign eng.ram_we     = we_mux;
   assign eng.init_start = init_start_q;
   assign eng.ksa_start  = ksa_start_q;
   assign eng.prga_start = prga_start_q;

   assign grant     = grant_q;
   assign key_out   = key_out_q;
   assign done      = done_q;
   assign error     = error_q;
   assign key_found = key_found_q;
   assign busy      = !(state_q inside {StIdle, StDone, StError});

endmodule

// File: tb/tb_s_mem_phase_controller.sv
// Bench for s_mem_phase_controller: each run is planned up front as a cycle timeline
// (phase windows, strobe cycles, done cycles) and every cycle is checked against it.
module tb_s_mem_phase_controller;

   localparam int unsigned TO   = 16;
   localparam int          MAXT = 600;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] key_in;
   logic [1:0]  grant;
   logic [23:0] key_out;
   logic        busy, done, key_found, error;

   int checks   = 0;
   int failures = 0;

   int          exp_grant  [MAXT];
   int          exp_strobe [MAXT];
   int          done_at    [MAXT];
   bit          ok_at      [MAXT];
   logic [23:0] exp_key    [MAXT];

   s_mem_phase_controller_if #(.RAM_WIDTH(8), .ADDR_WIDTH(8)) bus ();

   s_mem_phase_controller #(
      .RAM_WIDTH      (8),
      .ADDR_WIDTH     (8),
      .KEY_WIDTH      (24),
      .TIMEOUT_CYCLES (TO),
      .KEY_MAX        (24'h000003)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .key_in    (key_in),
      .eng       (bus),
      .grant     (grant),
      .key_out   (key_out),
      .busy      (busy),
      .done      (done),
      .key_found (key_found),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic drive_engines_random();
      bus.init_addr  = 8'($urandom);
      bus.ksa_addr   = 8'($urandom);
      bus.prga_addr  = 8'($urandom);
      bus.init_wdata = 8'($urandom);
      bus.ksa_wdata  = 8'($urandom);
      bus.prga_wdata = 8'($urandom);
      bus.init_we    = 1'($urandom);
      bus.ksa_we     = 1'($urandom);
      bus.prga_we    = 1'($urandom);
   endtask

   task automatic check_reset_values(input string name);
      bus.init_we = 1'b1;
      bus.ksa_we  = 1'b1;
      bus.prga_we = 1'b1;
      #1;
      checks++;
      if ({grant, bus.init_start, bus.ksa_start, bus.prga_start} !== 5'b0) begin
         failures++;
         $display("FAIL %s grant/strobes got=%b required=0", name,
                  {grant, bus.init_start, bus.ksa_start, bus.prga_start});
      end
      checks++;
      if ({busy, done, error, key_found} !== 4'b0 || key_out !== 24'h0) begin
         failures++;
         $display("FAIL %s status got=%b key_out=%h required=0", name,
                  {busy, done, error, key_found}, key_out);
      end
      checks++;
      if ({bus.ram_addr, bus.ram_wdata, bus.ram_we} !== 17'h0) begin
         failures++;
         $display("FAIL %s ram got=%h/%h/%b required=0", name, bus.ram_addr, bus.ram_wdata,
                  bus.ram_we);
      end
   endtask

   // mode: 0 random, 1 fixed 5-cycle engines with key_ok=1, 2 KSA never finishes,
   // 3 key search succeeding at key 2, 4 key search never succeeding.
   task automatic run(input logic [23:0] key, input int mode, input int abort_t,
                      input string name);
      int          t, d, end_t;
      bit          fin, err, found, ok, search;
      logic [23:0] k;
      logic [7:0]  ea, ew;
      logic        ewe;
`ifdef KEY_SEARCH_EN
      search = 1'b1;
`else
      search = 1'b0;
`endif
      for (int i = 0; i < MAXT; i++) begin
         exp_grant[i] = 0; exp_strobe[i] = 0; done_at[i] = 0; ok_at[i] = 0; exp_key[i] = key;
      end
      t = 1; k = key; fin = 0; err = 0; found = 0;
      while (!fin) begin
         ok = (mode == 1) ? 1'b1 : (mode == 3) ? (k == 24'd2) :
              (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         for (int ph = 1; ph <= 3 && !fin; ph++) begin
            case (mode)
               1:       d = 5;
               2:       d = (ph == 2) ? 20 : 5;
               3, 4:    d = $urandom_range(1, 10);
               default: d = $urandom_range(1, 18);
            endcase
            exp_strobe[t] = ph;
            if (d > int'(TO)) begin
               for (int i = t; i <= t + int'(TO); i++) begin exp_grant[i] = ph; exp_key[i] = k; end
               t = t + int'(TO) + 1; fin = 1; err = 1;
            end else begin
               for (int i = t; i <= t + d; i++) begin exp_grant[i] = ph; exp_key[i] = k; end
               done_at[t + d] = ph;
               if (ph == 3) ok_at[t + d] = ok;
               t = t + d + 1;
               if (ph == 3) begin
                  if (search && !ok && k < 24'd3) k = k + 24'd1;
                  else begin fin = 1; found = ok; end
               end
            end
         end
      end
      end_t = t;
      for (int i = end_t; i < MAXT; i++) exp_key[i] = k;

      @(posedge clk); #1;
      start = 1'b0; key_in = key;
      for (t = 0; t <= end_t + 3; t++) begin
         @(posedge clk); #1;
         if (abort_t > 0 && t == abort_t + 1) begin
            check_reset_values({name, "_rst"});
            reset = 1'b0;
            return;
         end
         checks++;
         if (grant !== 2'(exp_grant[t]) ||
             {bus.init_start, bus.ksa_start, bus.prga_start} !==
             {exp_strobe[t] == 1, exp_strobe[t] == 2, exp_strobe[t] == 3}) begin
            failures++;
            $display("FAIL %s grant/strobe t=%0d got=%0d/%b required=%0d/strobe%0d", name, t,
                     grant, {bus.init_start, bus.ksa_start, bus.prga_start}, exp_grant[t],
                     exp_strobe[t]);
         end
         if (t >= 1) begin
            checks++;
            if ({busy, done, error, key_found} !==
                {t < end_t, t >= end_t && !err, t >= end_t && err, t >= end_t && found} ||
                key_out !== exp_key[t]) begin
               failures++;
               $display("FAIL %s status t=%0d got=%b key=%h required=%b key=%h", name, t,
                        {busy, done, error, key_found}, key_out,
                        {t < end_t, t >= end_t && !err, t >= end_t && err, t >= end_t && found},
                        exp_key[t]);
            end
         end
         // Inputs for this cycle.
         if (t == 0 || t >= end_t - 1) start = 1'b1;
         else start = 1'($urandom_range(0, 1));
         bus.init_done = (done_at[t] == 1) || (exp_grant[t] != 1 && $urandom_range(0, 2) == 0);
         bus.ksa_done  = (done_at[t] == 2) || (exp_grant[t] != 2 && $urandom_range(0, 2) == 0);
         bus.prga_done = (done_at[t] == 3) || (exp_grant[t] != 3 && $urandom_range(0, 2) == 0);
         bus.prga_key_ok = (done_at[t] == 3) ? ok_at[t] : 1'($urandom_range(0, 1));
         drive_engines_random();
         if (mode == 1 && exp_grant[t] == 2) begin
            bus.ksa_addr = 8'h3C; bus.ksa_wdata = 8'hA5; bus.ksa_we = 1'b1; bus.init_we = 1'b1;
         end
         if (abort_t > 0 && t == abort_t) reset = 1'b1;
         #1;
         case (exp_grant[t])
            1:       begin ea = bus.init_addr; ew = bus.init_wdata; ewe = bus.init_we; end
            2:       begin ea = bus.ksa_addr;  ew = bus.ksa_wdata;  ewe = bus.ksa_we;  end
            3:       begin ea = bus.prga_addr; ew = bus.prga_wdata; ewe = bus.prga_we; end
            default: begin ea = 8'h0; ew = 8'h0; ewe = 1'b0; end
         endcase
         checks++;
         if (bus.ram_addr !== ea || bus.ram_wdata !== ew || bus.ram_we !== ewe) begin
            failures++;
            $display("FAIL %s ram_mux t=%0d got=%h/%h/%b required=%h/%h/%b", name, t,
                     bus.ram_addr, bus.ram_wdata, bus.ram_we, ea, ew, ewe);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; key_in = 24'h0;
      bus.init_done = 0; bus.ksa_done = 0; bus.prga_done = 0; bus.prga_key_ok = 0;
      drive_engines_random();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
   endtask

   task automatic test_single_pass();
      run(24'h000249, 1, 0, "single_pass");
   endtask

   task automatic test_mux();
      run(24'h00ABCD, 1, 0, "mux_ksa");
   endtask

   task automatic test_timeout();
      run(24'h123456, 2, 0, "timeout");
      run(24'h654321, 1, 0, "restart_after_error");
   endtask

   task automatic test_stray_strobes();
      for (int i = 0; i < 8; i++) run(24'($urandom), 0, 0, "random_stray");
   endtask

   task automatic test_reset_mid_ksa();
      run(24'h0000FF, 1, 9, "reset_mid_ksa");
      run(24'h00BEEF, 0, 0, "after_reset");
   endtask

   task automatic test_key_search();
`ifdef KEY_SEARCH_EN
      run(24'h000000, 3, 0, "search_found");
      run(24'h000000, 4, 0, "search_exhausted");
`endif
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_mux();
      test_timeout();
      test_stray_strobes();
      test_reset_mid_ksa();
      test_key_search();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
